// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS register file slice.
package mips_pkg;

    localparam int REG_ZERO       = 0;
    localparam int DATA_W_DEFAULT = 32;
    localparam int REGS_DEFAULT   = 32;

    // Register-file control state: clear sweep after reset, then normal operation.
    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_bypass_mux.sv
// Per-read-port lane selector: array word, overridden by the highest-index
// matching write port in the same cycle, and forced to zero for register 0
// when the hardwired zero register is enabled.
module rf_bypass_mux
    import mips_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int ADDR_W   = 5,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        array_word,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0]        lane_data
);

    // Later ports overwrite earlier matches, so the highest index wins.
    always_comb begin
        lane_data = array_word;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr)) begin
                lane_data = wr_data[j*DATA_W +: DATA_W];
            end
        end
        if ((ZERO_REG != 0) && (rd_addr == ADDR_W'(REG_ZERO))) begin
            lane_data = '0;
        end
    end

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS general-purpose register file with a post-reset clear
// sweep, same-cycle write-through bypass, optional hardwired zero register
// and highest-index-wins write priority.
//
// Stall contract: busy is a level signal. While it is high the pipeline must
// hold; every read lane returns zero and any write presented is dropped
// (never queued). Once busy falls the file accepts writes and reads every cycle.
module mips_regfile_mp
    import mips_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int DEPTH    = REGS_DEFAULT,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic                     busy
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    // Control state is kept in plain named signals so checkers can bind to it.
    rf_state_t         state;
    rf_state_t         state_nxt;
    logic [ADDR_W-1:0] clr_idx;
    logic [ADDR_W-1:0] clr_idx_nxt;

    logic [DATA_W-1:0] regs [DEPTH];

    // State and sweep-counter register; reset restarts the sweep from entry 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    // Next state: advance the sweep, leave CLEAR once the last entry is cleared.
    // In RUN the counter wraps to zero and simply holds there.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        if (state == RF_CLEAR) begin
            clr_idx_nxt = clr_idx + ADDR_W'(1);
            if (clr_idx == LAST_IDX) begin
                state_nxt = RF_RUN;
            end
        end
    end

    assign busy = (state == RF_CLEAR);

    // Storage: clear one entry per cycle during the sweep, otherwise commit
    // writes in port order so the highest-index port wins on a collision.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == RF_CLEAR) begin
                regs[clr_idx] <= '0;
            end else begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] &&
                        !((ZERO_REG != 0) && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(REG_ZERO)))) begin
                        regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // One bypass mux per read port; lanes are forced to zero during reset or the sweep.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] lane_addr;
        logic [DATA_W-1:0] lane_val;

        assign lane_addr = rd_addr[k*ADDR_W +: ADDR_W];

        rf_bypass_mux #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .NUM_WR   (NUM_WR),
            .ZERO_REG (ZERO_REG)
        ) u_mux (
            .rd_addr    (lane_addr),
            .array_word (regs[lane_addr]),
            .wr_en      (wr_en),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
            .lane_data  (lane_val)
        );

        assign rd_data[k*DATA_W +: DATA_W] = (busy || reset) ? '0 : lane_val;
    end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Self-checking bench for mips_regfile_mp (32x32, two read ports, two write ports).
module tb_mips_regfile_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic [NW-1:0]    wr_en   = '0;
    logic [NW*AW-1:0] wr_addr = '0;
    logic [NW*DW-1:0] wr_data = '0;
    logic             busy;

    mips_regfile_mp #(
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .NUM_RD   (NR),
        .NUM_WR   (NW),
        .ZERO_REG (1)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    // ---------------- reference model ----------------
    // Abstract view: a countdown of sweep cycles still owed, and an array that
    // becomes all-zero at the moment the countdown reaches zero.
    logic [DW-1:0] mem [DEPTH];
    int            clr_left = DEPTH;
    int            pass_cnt = 0;
    int            total    = 0;

    function automatic logic [AW-1:0] ra(input int k);
        return rd_addr[k*AW +: AW];
    endfunction
    function automatic logic [AW-1:0] wa(input int j);
        return wr_addr[j*AW +: AW];
    endfunction
    function automatic logic [DW-1:0] wd(input int j);
        return wr_data[j*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] exp_read(input int k);
        logic [DW-1:0] v;
        if (reset || clr_left > 0) return '0;
        if (ra(k) == 0) return '0;
        v = mem[ra(k)];
        for (int j = 0; j < NW; j++)
            if (wr_en[j] && wa(j) == ra(k)) v = wd(j);
        return v;
    endfunction

    task automatic model_edge();
        if (reset) begin
            clr_left = DEPTH;
        end else if (clr_left > 0) begin
            clr_left--;
            if (clr_left == 0)
                for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        end else begin
            for (int j = 0; j < NW; j++)
                if (wr_en[j] && wa(j) != 0) mem[wa(j)] = wd(j);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic set_wr(input int j, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[j]            = en;
        wr_addr[j*AW +: AW] = a;
        wr_data[j*DW +: DW] = d;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic randomize_inputs(input int addr_hi);
        for (int j = 0; j < NW; j++)
            set_wr(j, 1'($urandom_range(0, 1)), AW'($urandom_range(0, addr_hi)), $urandom);
        for (int k = 0; k < NR; k++)
            set_rd(k, AW'($urandom_range(0, addr_hi)));
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_lanes(input string tag);
        for (int k = 0; k < NR; k++)
            chk($sformatf("%s lane%0d addr%0d", tag, k, ra(k)), rd_data[k*DW +: DW], exp_read(k));
    endtask

    task automatic chk_busy(input string tag);
        chk(tag, DW'(busy), DW'(clr_left > 0 ? 1 : 0));
    endtask

    // Counts busy cycles from the current point, with random (ignored)
    // writes offered on every cycle. Bounded so a stuck busy cannot hang.
    task automatic run_sweep(input string tag, input logic hit_r3);
        int cnt;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            randomize_inputs(DEPTH - 1);
            if (hit_r3) set_wr(0, 1'b1, AW'(3), 32'hA5A5_0003);
            #1;
            chk_lanes({tag, " during sweep"});
            chk_busy({tag, " busy"});
            tick();
            cnt++;
        end
        chk({tag, " sweep length"}, DW'(cnt), DW'(DEPTH));
        wr_en = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        wr_en = '0;
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(0, AW'(i));
            set_rd(1, AW'(DEPTH - 1 - i));
            #1;
            chk({tag, " lane0"}, rd_data[0 +: DW], 32'h0);
            chk({tag, " lane1"}, rd_data[DW +: DW], 32'h0);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        // Reset held for two edges: busy high, lanes zero.
        tick();
        tick();
        #1;
        chk("reset busy", DW'(busy), 32'h1);
        chk_lanes("reset");
        reset = 1'b0;

        // Clear sweep: exactly DEPTH busy cycles, then everything reads zero.
        run_sweep("sweep1", 1'b0);
        chk("busy after sweep", DW'(busy), 32'h0);
        chk_all_zero("post sweep");

        // Write then read.
        set_wr(0, 1'b1, AW'(5), 32'hDEAD_BEEF);
        tick();
        wr_en = '0;
        set_rd(0, AW'(5));
        #1;
        chk("r5 readback", rd_data[0 +: DW], 32'hDEAD_BEEF);

        // Same-cycle bypass over a zero r9.
        set_rd(1, AW'(9));
        #1;
        chk("r9 before write", rd_data[DW +: DW], 32'h0);
        set_wr(0, 1'b1, AW'(9), 32'h1234_5678);
        #1;
        chk("r9 bypass", rd_data[DW +: DW], 32'h1234_5678);
        tick();
        wr_en = '0;
        #1;
        chk("r9 stored", rd_data[DW +: DW], 32'h1234_5678);

        // Zero register ignores writes, including same-cycle bypass.
        set_rd(0, AW'(0));
        set_rd(1, AW'(0));
        set_wr(0, 1'b1, AW'(0), 32'hFFFF_FFFF);
        set_wr(1, 1'b1, AW'(0), 32'hFFFF_FFFF);
        #1;
        chk("r0 bypass lane0", rd_data[0 +: DW], 32'h0);
        chk("r0 bypass lane1", rd_data[DW +: DW], 32'h0);
        tick();
        wr_en = '0;
        #1;
        chk("r0 stored lane0", rd_data[0 +: DW], 32'h0);
        chk("r0 stored lane1", rd_data[DW +: DW], 32'h0);

        // Two writers on r7: port 1 wins in bypass and in storage.
        set_wr(0, 1'b1, AW'(7), 32'h11);
        set_wr(1, 1'b1, AW'(7), 32'h22);
        set_rd(0, AW'(7));
        #1;
        chk("r7 priority bypass", rd_data[0 +: DW], 32'h22);
        tick();
        wr_en = '0;
        #1;
        chk("r7 priority stored", rd_data[0 +: DW], 32'h22);

        // Random traffic against the model; narrow address range forces collisions.
        for (int n = 0; n < 400; n++) begin
            randomize_inputs(n < 200 ? 7 : DEPTH - 1);
            #1;
            chk_lanes("random");
            chk_busy("random busy");
            tick();
        end
        wr_en = '0;

        // Plant a known non-zero r3 so the later zero check is meaningful.
        set_wr(0, 1'b1, AW'(3), 32'hCAFE_0003);
        tick();
        wr_en = '0;
        set_rd(0, AW'(3));
        #1;
        chk("r3 planted", rd_data[0 +: DW], 32'hCAFE_0003);

        // Reset, run 10 sweep cycles with r3 writes, then reset again mid-sweep.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            set_wr(0, 1'b1, AW'(3), 32'hBAD0_0000 | c);
            #1;
            chk_busy("partial sweep busy");
            chk_lanes("partial sweep");
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_sweep("sweep2", 1'b1);
        set_rd(0, AW'(3));
        #1;
        chk("r3 after sweep", rd_data[0 +: DW], 32'h0);
        chk_all_zero("post sweep2");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
